// File: rtl/wb_select_stage_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : wb_pkg
//  Description : Shared constants and state type for the writeback select stage.
//  Revision    : 1.0 - initial release
// ============================================================================
package wb_pkg;

    localparam logic [1:0] WB_ALU = 2'd0;
    localparam logic [1:0] WB_MEM = 2'd1;
    localparam logic [1:0] WB_PC4 = 2'd2;
    localparam logic [1:0] WB_IMM = 2'd3;

    localparam logic [2:0] F3_LB  = 3'b000;
    localparam logic [2:0] F3_LH  = 3'b001;
    localparam logic [2:0] F3_LW  = 3'b010;
    localparam logic [2:0] F3_LD  = 3'b011;
    localparam logic [2:0] F3_LBU = 3'b100;
    localparam logic [2:0] F3_LHU = 3'b101;
    localparam logic [2:0] F3_LWU = 3'b110;

    typedef enum logic [0:0] {
        ST_IDLE     = 1'b0,
        ST_WAIT_MEM = 1'b1
    } wb_state_e;

endpackage : wb_pkg
`default_nettype wire

// File: rtl/wb_select_stage_load_align.sv
`default_nettype none
// ============================================================================
//  Module      : load_align
//  Description : Selects the addressed lane of a raw read word and extends it.
//  Revision    : 1.0 - initial release
// ============================================================================
module load_align
    import wb_pkg::*;
#(
    parameter int XLEN = 32
) (
    input  logic [2:0]                  funct3,
    input  logic [$clog2(XLEN/8)-1:0]   byte_off,
    input  logic [XLEN-1:0]             rdata,
    output logic [XLEN-1:0]             ext_data
);

    localparam int OFF_W = $clog2(XLEN/8);

    logic [7:0]      byte_lane;
    logic [15:0]     half_lane;
    logic [XLEN-1:0] word_s;
    logic [XLEN-1:0] word_u;

    assign byte_lane = 8'(rdata >> {byte_off, 3'b000});
    // Halfword loads drop the low offset bit so the lane stays naturally aligned.
    assign half_lane = 16'(rdata >> {byte_off[OFF_W-1:1], 4'b0000});

    generate
        if (XLEN == 64) begin : g_x64
            logic [31:0] word_lo;
            assign word_lo = byte_off[2] ? rdata[63:32] : rdata[31:0];
            assign word_s  = {{32{word_lo[31]}}, word_lo};
            assign word_u  = {32'b0, word_lo};
        end else begin : g_x32
            assign word_s = rdata;
            assign word_u = rdata;
        end
    endgenerate

    always_comb begin
        ext_data = rdata;
        case (funct3)
            F3_LB:   ext_data = {{(XLEN-8){byte_lane[7]}}, byte_lane};
            F3_LBU:  ext_data = {{(XLEN-8){1'b0}}, byte_lane};
            F3_LH:   ext_data = {{(XLEN-16){half_lane[15]}}, half_lane};
            F3_LHU:  ext_data = {{(XLEN-16){1'b0}}, half_lane};
            F3_LW:   ext_data = word_s;
            F3_LWU:  ext_data = word_u;
            default: ext_data = rdata;
        endcase
    end

endmodule : load_align
`default_nettype wire

// File: rtl/wb_select_stage.sv
`default_nettype none
// ============================================================================
//  Module      : wb_select_stage
//  Description : Registered writeback source select with variable-latency loads.
//  Revision    : 1.0 - initial release
// ============================================================================
module wb_select_stage
    import wb_pkg::*;
#(
    parameter int XLEN     = 32,
    parameter int RA_W     = 5,
    parameter int MAX_WAIT = 15
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic                        in_valid,
    input  logic                        reg_write,
    input  logic [RA_W-1:0]             rd_addr,
    input  logic [1:0]                  wb_sel,
    input  logic [2:0]                  funct3,
    input  logic [$clog2(XLEN/8)-1:0]   byte_off,
    input  logic [XLEN-1:0]             alu_result,
    input  logic [XLEN-1:0]             pc_plus4,
    input  logic [XLEN-1:0]             imm,
    input  logic [XLEN-1:0]             mem_rdata,
    input  logic                        mem_rvalid,
    output logic                        stall,
    output logic                        rf_we,
    output logic [RA_W-1:0]             rf_waddr,
    output logic [XLEN-1:0]             rf_wdata,
    output logic                        err
);

    localparam int              OFF_W    = $clog2(XLEN/8);
    localparam int              CNT_W    = $clog2(MAX_WAIT+1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(MAX_WAIT-1);

    wb_state_e        state_q;
    logic [CNT_W-1:0] cnt_q;
    logic [RA_W-1:0]  rd_q;
    logic             rw_q;
    logic [2:0]       f3_q;
    logic [OFF_W-1:0] off_q;
    logic             rf_we_q;
    logic [RA_W-1:0]  rf_waddr_q;
    logic [XLEN-1:0]  rf_wdata_q;
    logic             err_q;

    logic [2:0]       la_funct3;
    logic [OFF_W-1:0] la_off;
    logic [XLEN-1:0]  load_data;
    logic [XLEN-1:0]  src_data;

    // While waiting, alignment must use the attributes captured with the load.
    assign la_funct3 = (state_q == ST_WAIT_MEM) ? f3_q  : funct3;
    assign la_off    = (state_q == ST_WAIT_MEM) ? off_q : byte_off;

    load_align #(.XLEN(XLEN)) u_load_align (
        .funct3   (la_funct3),
        .byte_off (la_off),
        .rdata    (mem_rdata),
        .ext_data (load_data)
    );

    always_comb begin
        src_data = alu_result;
        case (wb_sel)
            WB_PC4:  src_data = pc_plus4;
            WB_IMM:  src_data = imm;
            WB_MEM:  src_data = load_data;
            default: src_data = alu_result;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= ST_IDLE;
            cnt_q      <= '0;
            rd_q       <= '0;
            rw_q       <= 1'b0;
            f3_q       <= '0;
            off_q      <= '0;
            rf_we_q    <= 1'b0;
            rf_waddr_q <= '0;
            rf_wdata_q <= '0;
            err_q      <= 1'b0;
        end else begin
            rf_we_q <= 1'b0;
            case (state_q)
                ST_IDLE: begin
                    if (in_valid) begin
                        if (wb_sel != WB_MEM || mem_rvalid) begin
                            if (reg_write && rd_addr != '0) begin
                                rf_we_q    <= 1'b1;
                                rf_waddr_q <= rd_addr;
                                rf_wdata_q <= src_data;
                            end
                        end else begin
                            rd_q    <= rd_addr;
                            rw_q    <= reg_write;
                            f3_q    <= funct3;
                            off_q   <= byte_off;
                            cnt_q   <= '0;
                            state_q <= ST_WAIT_MEM;
                        end
                    end
                end
                ST_WAIT_MEM: begin
                    cnt_q <= cnt_q + 1'b1;
                    if (mem_rvalid) begin
                        if (rw_q && rd_q != '0) begin
                            rf_we_q    <= 1'b1;
                            rf_waddr_q <= rd_q;
                            rf_wdata_q <= load_data;
                        end
                        state_q <= ST_IDLE;
                    end else if (cnt_q == CNT_LAST) begin
                        err_q   <= 1'b1;
                        state_q <= ST_IDLE;
                    end
                end
                default: state_q <= ST_IDLE;
            endcase
        end
    end

    assign stall    = (state_q == ST_WAIT_MEM) && !mem_rvalid;
    assign rf_we    = rf_we_q;
    assign rf_waddr = rf_waddr_q;
    assign rf_wdata = rf_wdata_q;
    assign err      = err_q;

endmodule : wb_select_stage
`default_nettype wire

// File: tb/tb_wb_select_stage.sv
`default_nettype none
// ============================================================================
//  Module      : tb_wb_select_stage
//  Description : Directed and randomized self-checking bench for wb_select_stage.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_wb_select_stage;

    localparam int MAXW = 4;

    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid, reg_write, mem_rvalid;
    logic [4:0]  rd_addr;
    logic [1:0]  wb_sel;
    logic [2:0]  funct3;
    logic [1:0]  byte_off;
    logic [31:0] alu_result, pc_plus4, imm, mem_rdata;
    logic        stall, rf_we, err;
    logic [4:0]  rf_waddr;
    logic [31:0] rf_wdata;

    int n_chk  = 0;
    int n_fail = 0;

    logic [4:0]  exp_waddr;
    logic [31:0] exp_wdata;
    logic        exp_err;

    always #5 clk = ~clk;

    wb_select_stage #(.XLEN(32), .RA_W(5), .MAX_WAIT(MAXW)) dut (
        .clk        (clk),
        .rst        (rst),
        .in_valid   (in_valid),
        .reg_write  (reg_write),
        .rd_addr    (rd_addr),
        .wb_sel     (wb_sel),
        .funct3     (funct3),
        .byte_off   (byte_off),
        .alu_result (alu_result),
        .pc_plus4   (pc_plus4),
        .imm        (imm),
        .mem_rdata  (mem_rdata),
        .mem_rvalid (mem_rvalid),
        .stall      (stall),
        .rf_we      (rf_we),
        .rf_waddr   (rf_waddr),
        .rf_wdata   (rf_wdata),
        .err        (err)
    );

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic chk_outs(input string tag, input logic we);
        chk({tag, "_we"},    32'(rf_we),    32'(we));
        chk({tag, "_waddr"}, 32'(rf_waddr), 32'(exp_waddr));
        chk({tag, "_wdata"}, rf_wdata,      exp_wdata);
        chk({tag, "_err"},   32'(err),      32'(exp_err));
    endtask

    // Load result from the lane/extension rules, using plain arithmetic.
    function automatic logic [31:0] ref_load(input logic [2:0] f3, input int off, input logic [31:0] w);
        longint unsigned v;
        int              off2;
        case (f3)
            3'b000, 3'b100: begin
                v = (w >> (8*off)) & 'hFF;
                if (f3 == 3'b000 && v >= 128) v = v + 64'hFFFF_FF00;
            end
            3'b001, 3'b101: begin
                off2 = off - (off % 2);
                v = (w >> (8*off2)) & 'hFFFF;
                if (f3 == 3'b001 && v >= 32768) v = v + 64'hFFFF_0000;
            end
            default: v = w;
        endcase
        return v[31:0];
    endfunction

    task automatic idle_inputs();
        in_valid = 1'b0; reg_write = 1'b0; rd_addr = '0; wb_sel = '0; funct3 = '0;
        byte_off = '0; alu_result = '0; pc_plus4 = '0; imm = '0; mem_rdata = '0;
        mem_rvalid = 1'b0;
    endtask

    task automatic issue(input logic [1:0] sel, input logic [4:0] rd, input logic [2:0] f3,
                         input logic [1:0] off, input logic rv);
        in_valid = 1'b1; reg_write = 1'b1; wb_sel = sel; rd_addr = rd;
        funct3 = f3; byte_off = off; mem_rvalid = rv;
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: observed=timeout expected=finish");
        $fatal(1, "bench timeout");
    end

    initial begin
        logic [1:0]  sel;
        logic        rw;
        logic [4:0]  rd;
        logic [2:0]  f3;
        logic [1:0]  off;
        logic [31:0] a, p, im, md;
        int          lat;

        rst = 1'b1;
        idle_inputs();
        exp_waddr = '0; exp_wdata = '0; exp_err = 1'b0;
        step(); step();
        chk("rst_stall", 32'(stall), 0);
        chk_outs("rst", 1'b0);
        rst = 1'b0;
        step();

        // ALU path
        issue(WB_ALU_C(), 5'd5, 3'b000, 2'd0, 1'b0);
        alu_result = 32'h1234;
        #1 chk("alu_stall", 32'(stall), 0);
        step();
        idle_inputs();
        exp_waddr = 5'd5; exp_wdata = 32'h1234;
        chk_outs("alu", 1'b1);
        chk("alu_stall2", 32'(stall), 0);
        step();
        chk_outs("alu_hold", 1'b0);

        // Zero-wait LB and LHU
        issue(2'd1, 5'd7, 3'b000, 2'd3, 1'b1);
        mem_rdata = 32'h80FF_7F01;
        step();
        exp_waddr = 5'd7; exp_wdata = 32'hFFFF_FF80;
        chk_outs("lb0", 1'b1);
        issue(2'd1, 5'd8, 3'b101, 2'd2, 1'b1);
        step();
        idle_inputs();
        exp_waddr = 5'd8; exp_wdata = 32'h0000_80FF;
        chk_outs("lhu0", 1'b1);

        // Three-cycle LW with in_valid noise during the wait
        issue(2'd1, 5'd9, 3'b010, 2'd0, 1'b0);
        step();
        issue(2'd0, 5'd3, 3'b000, 2'd0, 1'b0);
        alu_result = 32'hAAAA_5555;
        #1 chk("lw3_stall1", 32'(stall), 1);
        chk("lw3_we1", 32'(rf_we), 0);
        step();
        #1 chk("lw3_stall2", 32'(stall), 1);
        step();
        in_valid = 1'b0; mem_rvalid = 1'b1; mem_rdata = 32'hDEAD_BEEF;
        #1 chk("lw3_stall3", 32'(stall), 0);
        step();
        idle_inputs();
        exp_waddr = 5'd9; exp_wdata = 32'hDEAD_BEEF;
        chk_outs("lw3", 1'b1);
        step();
        chk_outs("lw3_after", 1'b0);

        // x0 suppression on a waited load, then confirm IDLE with an ALU op
        issue(2'd1, 5'd0, 3'b010, 2'd0, 1'b0);
        step();
        mem_rvalid = 1'b1; in_valid = 1'b0; mem_rdata = 32'h1357_9BDF;
        step();
        idle_inputs();
        chk_outs("x0", 1'b0);
        issue(2'd0, 5'd4, 3'b000, 2'd0, 1'b0);
        alu_result = 32'h0BAD_F00D;
        step();
        idle_inputs();
        exp_waddr = 5'd4; exp_wdata = 32'h0BAD_F00D;
        chk_outs("x0_idle", 1'b1);

        // Timeout
        issue(2'd1, 5'd6, 3'b010, 2'd0, 1'b0);
        step();
        idle_inputs();
        for (int k = 1; k <= MAXW; k++) begin
            #1 chk($sformatf("to_stall%0d", k), 32'(stall), 1);
            chk($sformatf("to_we%0d", k), 32'(rf_we), 0);
            chk($sformatf("to_err%0d", k), 32'(err), 0);
            step();
        end
        exp_err = 1'b1;
        chk("to_idle_stall", 32'(stall), 0);
        chk_outs("to", 1'b0);
        issue(2'd3, 5'd10, 3'b000, 2'd0, 1'b0);
        imm = 32'hFEED_0001;
        step();
        idle_inputs();
        exp_waddr = 5'd10; exp_wdata = 32'hFEED_0001;
        chk_outs("to_sticky", 1'b1);

        // Reset in cycle 2 of WAIT_MEM
        issue(2'd1, 5'd11, 3'b010, 2'd0, 1'b0);
        step();
        idle_inputs();
        step();
        rst = 1'b1;
        #1;
        exp_waddr = '0; exp_wdata = '0; exp_err = 1'b0;
        chk("rstw_stall", 32'(stall), 0);
        chk_outs("rstw", 1'b0);
        step();
        rst = 1'b0;
        mem_rvalid = 1'b1; mem_rdata = 32'h7777_7777;
        step();
        mem_rvalid = 1'b0;
        chk_outs("rstw_late", 1'b0);

        // Randomized transactions against the reference model
        for (int t = 0; t < 300; t++) begin
            sel = 2'($urandom_range(0, 3));
            rw  = 1'($urandom_range(0, 1));
            rd  = 5'($urandom_range(0, 31));
            f3  = 3'($urandom_range(0, 7));
            off = 2'($urandom_range(0, 3));
            a = $urandom; p = $urandom; im = $urandom; md = $urandom;
            lat = (sel == 2'd1) ? $urandom_range(0, MAXW + 1) : 0;
            in_valid = 1'b1; reg_write = rw; rd_addr = rd; wb_sel = sel; funct3 = f3;
            byte_off = off; alu_result = a; pc_plus4 = p; imm = im;
            mem_rdata  = (lat == 0) ? md : $urandom;
            mem_rvalid = (sel == 2'd1) ? (lat == 0) : 1'($urandom_range(0, 1));
            if (lat > 0) begin
                for (int c = 1; c <= MAXW && c <= lat; c++) begin
                    step();
                    in_valid = 1'($urandom_range(0, 1)); reg_write = 1'($urandom_range(0, 1));
                    rd_addr = 5'($urandom); wb_sel = 2'($urandom); funct3 = 3'($urandom);
                    byte_off = 2'($urandom); alu_result = $urandom;
                    mem_rvalid = (c == lat);
                    mem_rdata  = (c == lat) ? md : $urandom;
                    #1 chk("rnd_stall", 32'(stall), 32'(c != lat));
                    chk("rnd_wait_we", 32'(rf_we), 0);
                end
            end
            step();
            idle_inputs();
            if (lat > MAXW) begin
                exp_err = 1'b1;
                chk_outs("rnd_to", 1'b0);
            end else if (rw && rd != 5'd0) begin
                exp_waddr = rd;
                case (sel)
                    2'd0: exp_wdata = a;
                    2'd1: exp_wdata = ref_load(f3, int'(off), md);
                    2'd2: exp_wdata = p;
                    default: exp_wdata = im;
                endcase
                chk_outs("rnd", 1'b1);
            end else begin
                chk_outs("rnd_nowr", 1'b0);
            end
            chk("rnd_stall_end", 32'(stall), 0);
            if ($urandom_range(0, 3) == 0) begin
                mem_rvalid = 1'b1; mem_rdata = $urandom;
                step();
                mem_rvalid = 1'b0;
                chk_outs("rnd_stray", 1'b0);
            end
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

    function automatic logic [1:0] WB_ALU_C();
        return 2'd0;
    endfunction

endmodule : tb_wb_select_stage
`default_nettype wire
